// File: rtl/regwrite_decoder.sv
// Buffers register-file write-backs in a small in-order FIFO and drains them as
// registered one-hot write enables, holding off while the register file stalls.
module regwrite_decoder #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rf_stall,
  output logic [31:0]           wr_en,
  output logic [DATA_WIDTH-1:0] wr_data_q,
  output logic [31:0]           pending,
  output logic [2:0]            count
);

  localparam int         PTR_W   = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [4:0] ZERO_REG = 5'd31;

  // Valid/ready: a request is taken on an edge where wr_valid && wr_ready;
  // wr_ready depends only on current occupancy, never on a same-edge pop.

  logic [4:0]            addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [2:0]            count_q, count_d;
  logic [31:0]           wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  push, pop;
  logic [4:0]            head_addr;
  logic [PTR_W-1:0]      off;

  function automatic logic [31:0] decode(input logic [4:0] a);
    decode = (a == ZERO_REG) ? 32'd0 : (32'd1 << a);
  endfunction

  assign wr_ready  = !reset && (count_q < DEPTH_C);
  assign push      = wr_valid && wr_ready;
  assign pop       = (count_q != 3'd0) && !rf_stall;
  assign head_addr = addr_mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en_d  = 32'd0;
    data_d   = data_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wr_en_d  = decode(head_addr);
      data_d   = data_mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    pending = 32'd0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if ((3'(off) < count_q) && (addr_mem_q[i] != ZERO_REG))
        pending[addr_mem_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 3'd0;
      wr_en_q  <= 32'd0;
      data_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wr_en_q  <= wr_en_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= wr_addr;
      data_mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_data_q = data_q;
  assign count     = count_q;

endmodule
